// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a bounded hold time. A grant is kept while the
// grantee keeps requesting, up to MAX_HOLD consecutive cycles. The next search
// then starts just past the outgoing grantee, so it has the lowest priority.
//
//  state | meaning
//  ------+-----------------------------------------------
//  IDLE  | no grant outstanding; outputs all zero
//  GRANT | one requester granted; hold_cnt counts its cycles
module round_robin_arbiter #(
    parameter int SIZE     = 3,
    parameter int WIDTH    = 1 << SIZE,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt,
    output logic [SIZE-1:0]  gnt_idx,
    output logic             gnt_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [SIZE-1:0]  ptr_q, ptr_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic [SIZE-1:0]  gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;

    logic             any_req;
    logic             release_now;
    logic [SIZE-1:0]  after_idx;
    logic [SIZE-1:0]  winner_from_ptr;
    logic [SIZE-1:0]  winner_after;

    // First requester at or after 'start', wrapping modulo WIDTH.
    function automatic logic [SIZE-1:0] pick(input logic [WIDTH-1:0] r,
                                             input logic [SIZE-1:0]  start);
        logic [SIZE-1:0] win;
        logic            found;
        int              idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = int'(start) + i;
            if (idx >= WIDTH) idx = idx - WIDTH;
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx[SIZE-1:0];
            end
        end
        return win;
    endfunction

    // Index following 'cur', wrapping from WIDTH-1 back to 0.
    function automatic logic [SIZE-1:0] next_idx(input logic [SIZE-1:0] cur);
        int n;
        n = int'(cur) + 1;
        if (n >= WIDTH) n = 0;
        return n[SIZE-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] onehot(input logic [SIZE-1:0] idx);
        return {{(WIDTH-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Shared decode terms for the next-state logic.
    always_comb begin
        any_req         = |req;
        release_now     = !req[gnt_idx_q] || (hold_cnt_q == HOLD_LAST) || !en;
        after_idx       = next_idx(gnt_idx_q);
        winner_from_ptr = pick(req, ptr_q);
        winner_after    = pick(req, after_idx);
    end

    // Next-state: arbitration, hold counting and release/hand-over.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;

        unique case (state_q)
            IDLE: begin
                if (en && any_req) begin
                    state_d     = GRANT;
                    hold_cnt_d  = 8'd0;
                    gnt_idx_d   = winner_from_ptr;
                    gnt_d       = onehot(winner_from_ptr);
                    gnt_valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d      = after_idx;
                    hold_cnt_d = 8'd0;
                    if (en && any_req) begin
                        // Hand straight over; outgoing index is searched last.
                        gnt_idx_d   = winner_after;
                        gnt_d       = onehot(winner_after);
                        gnt_valid_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        gnt_idx_d   = '0;
                        gnt_d       = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter (SIZE=3, MAX_HOLD=4).
// "Cycle n" is the output value seen just after edge n-1, where edge 0 is the
// first edge after reset is released.
module tb_round_robin_arbiter;

    localparam int SIZE     = 3;
    localparam int WIDTH    = 1 << SIZE;
    localparam int MAX_HOLD = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] gnt;
    logic [SIZE-1:0]  gnt_idx;
    logic             gnt_valid;

    int total;
    int bad;

    round_robin_arbiter #(
        .SIZE     (SIZE),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with busy inputs; leaves rst low so the next edge is edge 0.
    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        req = 8'hFF;
        step();
        step();
        rst = 1'b0;
        req = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (gnt !== 8'h00) begin
            bad++;
            $display("FAIL reset_gnt: got %h want 00", gnt);
        end
        total++;
        if (gnt_idx !== 3'd0) begin
            bad++;
            $display("FAIL reset_idx: got %0d want 0", gnt_idx);
        end
        total++;
        if (gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %b want 0", gnt_valid);
        end
    endtask

    task automatic test_idle();
        do_reset();
        req = 8'h00;
        for (int c = 1; c <= 20; c++) begin
            step();
            total++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle c%0d: got gnt=%h v=%b want 00/0", c, gnt, gnt_valid);
            end
        end
    endtask

    task automatic test_rotate();
        logic [WIDTH-1:0] exp_g;
        logic [SIZE-1:0]  exp_i;
        do_reset();
        req = 8'h24;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c >= 5 && c <= 8) begin
                exp_g = 8'h20;
                exp_i = 3'd5;
            end else begin
                exp_g = 8'h04;
                exp_i = 3'd2;
            end
            total++;
            if (gnt !== exp_g || gnt_idx !== exp_i || gnt_valid !== 1'b1) begin
                bad++;
                $display("FAIL rotate c%0d: got gnt=%h idx=%0d v=%b want %h/%0d/1",
                         c, gnt, gnt_idx, gnt_valid, exp_g, exp_i);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h80;
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 3) req = 8'h00;
            total++;
            if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
                bad++;
                $display("FAIL wrap_hold c%0d: got gnt=%h idx=%0d want 80/7", c, gnt, gnt_idx);
            end
        end
        for (int c = 4; c <= 5; c++) begin
            step();
            total++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
                bad++;
                $display("FAIL wrap_drop c%0d: got gnt=%h v=%b idx=%0d want 00/0/0",
                         c, gnt, gnt_valid, gnt_idx);
            end
        end
        req = 8'h81;
        for (int c = 1; c <= 6; c++) begin
            step();
            total++;
            if (c <= 4) begin
                if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
                    bad++;
                    $display("FAIL wrap_regrant c%0d: got gnt=%h idx=%0d want 01/0", c, gnt, gnt_idx);
                end
            end else begin
                if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
                    bad++;
                    $display("FAIL wrap_next c%0d: got gnt=%h idx=%0d want 80/7", c, gnt, gnt_idx);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h08;
        for (int c = 1; c <= 12; c++) begin
            step();
            total++;
            if (gnt !== 8'h08 || gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin
                bad++;
                $display("FAIL timeout c%0d: got gnt=%h idx=%0d v=%b want 08/3/1",
                         c, gnt, gnt_idx, gnt_valid);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [SIZE-1:0] exp_i;
        do_reset();
        req = 8'hFF;
        for (int c = 1; c <= 14; c++) begin
            step();
            exp_i = 3'((c - 1) / MAX_HOLD);
            total++;
            if (gnt_idx !== exp_i || gnt !== (8'h01 << exp_i)) begin
                bad++;
                $display("FAIL rstmid_seq c%0d: got gnt=%h idx=%0d want idx %0d",
                         c, gnt, gnt_idx, exp_i);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
            bad++;
            $display("FAIL rstmid_clear: got gnt=%h v=%b idx=%0d want 00/0/0", gnt, gnt_valid, gnt_idx);
        end
        step();
        total++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_first: got gnt=%h idx=%0d v=%b want 01/0/1", gnt, gnt_idx, gnt_valid);
        end
    endtask

    task automatic test_en_drop();
        do_reset();
        req = 8'hFF;
        for (int c = 1; c <= 5; c++) step();
        total++;
        if (gnt !== 8'h02 || gnt_idx !== 3'd1) begin
            bad++;
            $display("FAIL endrop_pre: got gnt=%h idx=%0d want 02/1", gnt, gnt_idx);
        end
        en = 1'b0;
        step();
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL endrop_off: got gnt=%h v=%b want 00/0", gnt, gnt_valid);
        end
        step();
        total++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL endrop_stay: got gnt=%h v=%b want 00/0", gnt, gnt_valid);
        end
        en = 1'b1;
        step();
        total++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL endrop_resume: got gnt=%h idx=%0d v=%b want 04/2/1", gnt, gnt_idx, gnt_valid);
        end
    endtask

    // Grant to idx 1 must ignore a new lower-index request until it releases.
    task automatic test_no_preempt();
        do_reset();
        req = 8'h02;
        step();
        req = 8'h03;
        for (int c = 2; c <= 4; c++) begin
            step();
            total++;
            if (gnt !== 8'h02) begin
                bad++;
                $display("FAIL nopreempt c%0d: got gnt=%h want 02", c, gnt);
            end
        end
        req = 8'h01;
        step();
        step();
        total++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            bad++;
            $display("FAIL nopreempt_handover: got gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        req   = '0;
        test_reset();
        test_idle();
        test_rotate();
        test_wrap();
        test_timeout();
        test_rst_mid();
        test_en_drop();
        test_no_preempt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The block SHALL have parameter SIZE, default 3: requester index width.
REQ-002 The block SHALL have parameter WIDTH, default 1 << SIZE: number of requesters.
REQ-003 The block SHALL have parameter MAX_HOLD, default 8: maximum consecutive grant cycles, legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: arbitration enable.
REQ-007 The block SHALL have port req, input, WIDTH bits: per-requester request level.
REQ-008 The block SHALL have port gnt, output, WIDTH bits: one-hot grant.
REQ-009 The block SHALL have port gnt_idx, output, SIZE bits: binary index of the current grantee.
REQ-010 The block SHALL have port gnt_valid, output, 1 bit: a grant is active.

Function
REQ-011 The block SHALL implement two states: IDLE (no grant) and GRANT (one grantee).
REQ-012 Internal state SHALL be: priority pointer ptr (SIZE bits) and hold counter hold_cnt (8 bits).
REQ-013 All outputs SHALL be registered.
REQ-014 gnt SHALL equal the one-hot decode of gnt_idx when gnt_valid=1 and SHALL be all-zero otherwise; at most one bit is ever set.
REQ-015 Winner selection SHALL pick the first i with req[i]=1, searching ptr, ptr+1, ... modulo WIDTH, wrapping from WIDTH-1 to 0.
REQ-016 IDLE with en=1 and |req=1 at an edge: the block SHALL enter GRANT at that edge with the selected winner and hold_cnt=0, giving 1-cycle request-to-grant latency.
REQ-017 IDLE with en=0 or req=0: the block SHALL remain in IDLE.
REQ-018 In GRANT, each edge without release SHALL increment hold_cnt by 1.
REQ-019 GRANT release SHALL occur at an edge where any of the following holds: req[gnt_idx]=0; hold_cnt==MAX_HOLD-1 (grant has lasted MAX_HOLD cycles); en=0.
REQ-020 On release, ptr SHALL become (gnt_idx+1) mod WIDTH, wrapping from WIDTH-1 to 0.
REQ-021 On release with en=1 and |req=1: the block SHALL switch directly to the next winner at the same edge, with no idle bubble and hold_cnt=0.
  - The search SHALL start at gnt_idx+1, so the outgoing requester has lowest priority.
  - The outgoing requester SHALL be re-granted only if it is the sole requester.
  - A sole requester that times out SHALL see gnt_valid stay 1 continuously.
REQ-022 On release with en=0 or req=0: the block SHALL return to IDLE, and gnt_valid, gnt and gnt_idx SHALL be 0 from the next cycle.
REQ-023 Changes on non-granted req bits during GRANT SHALL have no effect until release.
REQ-024 When several release conditions coincide, they SHALL act as a single release; the ptr update SHALL be identical.
REQ-025 Release on a dropped request SHALL take effect one cycle after req[gnt_idx] is sampled low; gnt stays high during that sampling cycle.

Reset
REQ-026 rst=1 at an edge SHALL force: state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, ptr=0, hold_cnt=0.
REQ-027 rst SHALL take priority over all other inputs, including mid-grant.
REQ-028 Outputs SHALL be zero in the cycle after the rst edge.
REQ-029 The first arbitration after reset SHALL start its search at index 0.

Verification
All scenarios use SIZE=3, MAX_HOLD=4; cycle 0 is the first edge after rst deasserts; en=1 unless stated.
REQ-030 The bench SHALL cover: req=8'h00 for 20 cycles -> gnt=0 and gnt_valid=0 throughout.
REQ-031 The bench SHALL cover: req=8'h24 held -> gnt=8'h04 (idx 2) for cycles 1-4, then 8'h20 (idx 5) for cycles 5-8, then 8'h04 again, with no gap.
REQ-032 The bench SHALL cover: req=8'h80 for cycles 0-2, then 0 -> gnt=8'h80 for cycles 1-3, gnt=0 from cycle 4. Then req=8'h81 -> ptr has wrapped to 0, so idx 0 is granted first.
REQ-033 The bench SHALL cover: req=8'h08 held for 12 cycles -> gnt=8'h08 and gnt_valid=1 continuously from cycle 1 (timeout re-grant).
REQ-034 The bench SHALL cover: req=8'hFF, rst pulsed for 1 cycle while idx 3 is granted -> gnt=0 in the cycle after the rst edge, then idx 0 granted.
REQ-035 The bench SHALL cover: en dropped to 0 during a grant of idx 1 -> gnt=0 the next cycle. Then en=1 with req=8'hFF -> idx 2 granted.
